lives_manager: RTL and testbench

Upstream game-logic stage that owns the player's life count and drives the `lives` input of the life-icon bitmap drawer. It converts raw player-collision events and bonus-life events into a saturating 2-bit life count. It enforces a post-hit invulnerability window counted in frames and flags game over. It also produces a blink-enable for the player sprite during invulnerability and a one-cycle life-lost pulse for the sound block.

---
 rtl/lives_manager.sv | 168 ++++++++++++++++
 tb/tb_lives_manager.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lives_manager.sv
// lives_manager: owns the player's saturating 2-bit life count, the post-hit
//   invulnerability window (counted in video frames), sprite blink and game-over flag.
// Ports:
//   clk, resetN      - clock, asynchronous active-low reset
//   startGame        - restarts the game from any state (highest priority)
//   playerHit        - collision level; only its rising edge costs a life
//   bonusLife        - one-cycle pulse awarding a life (saturates at MAX_LIVES)
//   startOfFrame     - one-cycle pulse per video frame; paces invulnerability/blink
//   lives            - current life count for the life-icon drawer
//   gameOver         - high while in GAME_OVER
//   invulnerable     - high while in INVULN
//   playerVisible    - player sprite enable (blinks during INVULN)
//   lifeLostPulse    - one-cycle pulse per accepted hit
// All outputs are registered; a hit is reflected on the outputs one cycle after the rise.
module lives_manager #(
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startGame,
  input  logic       playerHit,
  input  logic       bonusLife,
  input  logic       startOfFrame,
  output logic [1:0] lives,
  output logic       gameOver,
  output logic       invulnerable,
  output logic       playerVisible,
  output logic       lifeLostPulse
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [1:0] INIT_L    = INIT_LIVES[1:0];
  localparam logic [1:0] MAX_L     = MAX_LIVES[1:0];
  localparam logic [2:0] MAX_W     = {1'b0, MAX_L};
  localparam logic [7:0] INVULN_N  = INVULN_FRAMES[7:0];
  localparam logic [7:0] BLINK_TOP = 8'(BLINK_FRAMES - 1);

  state_t     state_q;
  logic [1:0] lives_q;
  logic       game_over_q;
  logic       invuln_q;
  logic       visible_q;
  logic       pulse_q;
  logic       hit_dly_q;
  logic [7:0] invuln_cnt_q;
  logic [7:0] blink_cnt_q;

  logic       hit_edge;
  logic [2:0] hit_sum;
  logic [2:0] hit_dec;
  logic [1:0] hit_lives_d;
  logic [2:0] bonus_sum;
  logic [1:0] bonus_lives_d;

  // A held collision level counts once: only the 0->1 transition is a hit.
  assign hit_edge = playerHit & ~hit_dly_q;

  // Candidate life counts: hit (with a coincident bonus folded in) and bonus alone.
  // Both clamp to [0, MAX_LIVES] using a 3-bit intermediate to avoid wrap.
  always_comb begin
    hit_sum       = {1'b0, lives_q} + {2'b00, bonusLife};
    hit_dec       = (hit_sum == 3'd0) ? 3'd0 : hit_sum - 3'd1;
    hit_lives_d   = (hit_dec > MAX_W) ? MAX_L : hit_dec[1:0];
    bonus_sum     = {1'b0, lives_q} + 3'd1;
    bonus_lives_d = (bonus_sum > MAX_W) ? MAX_L : bonus_sum[1:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      lives_q      <= 2'd0;
      game_over_q  <= 1'b0;
      invuln_q     <= 1'b0;
      visible_q    <= 1'b0;
      pulse_q      <= 1'b0;
      hit_dly_q    <= 1'b0;
      invuln_cnt_q <= 8'd0;
      blink_cnt_q  <= 8'd0;
    end else begin
      hit_dly_q <= playerHit;
      pulse_q   <= 1'b0;

      if (startGame) begin
        // Restart wins over everything; same-cycle hit/bonus are dropped.
        state_q      <= PLAYING;
        lives_q      <= INIT_L;
        game_over_q  <= 1'b0;
        invuln_q     <= 1'b0;
        visible_q    <= 1'b1;
        invuln_cnt_q <= 8'd0;
        blink_cnt_q  <= 8'd0;
      end else begin
        case (state_q)
          IDLE: begin
          end

          PLAYING: begin
            if (hit_edge) begin
              pulse_q   <= 1'b1;
              lives_q   <= hit_lives_d;
              visible_q <= 1'b0;
              if (hit_lives_d == 2'd0) begin
                state_q     <= GAME_OVER;
                game_over_q <= 1'b1;
              end else begin
                state_q      <= INVULN;
                invuln_q     <= 1'b1;
                invuln_cnt_q <= INVULN_N;
                blink_cnt_q  <= 8'd0;
              end
            end else if (bonusLife) begin
              lives_q <= bonus_lives_d;
            end
          end

          INVULN: begin
            if (bonusLife) begin
              lives_q <= bonus_lives_d;
            end
            if (startOfFrame) begin
              if (invuln_cnt_q <= 8'd1) begin
                // Window closes on the frame that takes the counter to zero.
                state_q      <= PLAYING;
                invuln_q     <= 1'b0;
                visible_q    <= 1'b1;
                invuln_cnt_q <= 8'd0;
                blink_cnt_q  <= 8'd0;
              end else begin
                invuln_cnt_q <= invuln_cnt_q - 8'd1;
                if (blink_cnt_q >= BLINK_TOP) begin
                  blink_cnt_q <= 8'd0;
                  visible_q   <= ~visible_q;
                end else begin
                  blink_cnt_q <= blink_cnt_q + 8'd1;
                end
              end
            end
          end

          GAME_OVER: begin
            lives_q     <= 2'd0;
            game_over_q <= 1'b1;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign lives         = lives_q;
  assign gameOver      = game_over_q;
  assign invulnerable  = invuln_q;
  assign playerVisible = visible_q;
  assign lifeLostPulse = pulse_q;

endmodule

// File: tb/tb_lives_manager.sv
module tb_lives_manager;

  logic       clk;
  logic       resetN;
  logic       startGame;
  logic       playerHit;
  logic       bonusLife;
  logic       startOfFrame;
  logic [1:0] lives;
  logic       gameOver;
  logic       invulnerable;
  logic       playerVisible;
  logic       lifeLostPulse;

  int checks;
  int failures;

  lives_manager dut (
    .clk           (clk),
    .resetN        (resetN),
    .startGame     (startGame),
    .playerHit     (playerHit),
    .bonusLife     (bonusLife),
    .startOfFrame  (startOfFrame),
    .lives         (lives),
    .gameOver      (gameOver),
    .invulnerable  (invulnerable),
    .playerVisible (playerVisible),
    .lifeLostPulse (lifeLostPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One startOfFrame pulse followed by one idle cycle.
  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic test_reset();
    resetN = 1'b0; startGame = 1'b0; playerHit = 1'b0; bonusLife = 1'b0; startOfFrame = 1'b0;
    step(); step();
    checks++; if (lives !== 2'd0) begin failures++; $display("FAIL reset_lives got=%0d exp=0", lives); end
    checks++; if (gameOver !== 1'b0) begin failures++; $display("FAIL reset_gameOver got=%0b exp=0", gameOver); end
    checks++; if (invulnerable !== 1'b0) begin failures++; $display("FAIL reset_invuln got=%0b exp=0", invulnerable); end
    checks++; if (playerVisible !== 1'b0) begin failures++; $display("FAIL reset_visible got=%0b exp=0", playerVisible); end
    checks++; if (lifeLostPulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%0b exp=0", lifeLostPulse); end
    resetN = 1'b1;
    step();
    // Inputs other than startGame are ignored in IDLE.
    bonusLife = 1'b1; playerHit = 1'b1; step(); bonusLife = 1'b0; playerHit = 1'b0; step();
    checks++; if (lives !== 2'd0 || playerVisible !== 1'b0) begin failures++; $display("FAIL idle_ignore lives=%0d vis=%0b exp lives=0 vis=0", lives, playerVisible); end
  endtask

  task automatic test_start();
    startGame = 1'b1; step(); startGame = 1'b0;
    checks++; if (lives !== 2'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", lives); end
    checks++; if (playerVisible !== 1'b1) begin failures++; $display("FAIL start_visible got=%0b exp=1", playerVisible); end
    checks++; if (gameOver !== 1'b0 || invulnerable !== 1'b0) begin failures++; $display("FAIL start_flags go=%0b inv=%0b exp 0 0", gameOver, invulnerable); end
  endtask

  task automatic test_hit_hold_and_blink();
    int pulses;
    logic exp_vis;
    playerHit = 1'b1; step();
    checks++; if (lives !== 2'd2) begin failures++; $display("FAIL hit_lives got=%0d exp=2", lives); end
    checks++; if (lifeLostPulse !== 1'b1) begin failures++; $display("FAIL hit_pulse got=%0b exp=1", lifeLostPulse); end
    checks++; if (invulnerable !== 1'b1 || playerVisible !== 1'b0) begin failures++; $display("FAIL hit_invuln inv=%0b vis=%0b exp 1 0", invulnerable, playerVisible); end
    pulses = 0;
    for (int i = 0; i < 49; i++) begin
      step();
      if (lifeLostPulse) pulses++;
    end
    playerHit = 1'b0;
    checks++; if (pulses != 0 || lives !== 2'd2) begin failures++; $display("FAIL hold_once extra_pulses=%0d lives=%0d exp 0 2", pulses, lives); end
    for (int k = 1; k < 120; k++) begin
      frame();
      exp_vis = ((k / 8) % 2) == 1;
      checks++; if (playerVisible !== exp_vis || invulnerable !== 1'b1) begin
        failures++; $display("FAIL blink frame=%0d vis=%0b inv=%0b exp vis=%0b inv=1", k, playerVisible, invulnerable, exp_vis);
      end
      if (k <= 3) begin
        playerHit = 1'b1; step();
        checks++; if (lifeLostPulse !== 1'b0 || lives !== 2'd2) begin failures++; $display("FAIL invuln_hit%0d pulse=%0b lives=%0d exp 0 2", k, lifeLostPulse, lives); end
        playerHit = 1'b0; step();
      end
    end
    // Hit rises during INVULN and is still held as the window ends.
    playerHit = 1'b1; step();
    frame();
    checks++; if (invulnerable !== 1'b0 || playerVisible !== 1'b1 || lives !== 2'd2) begin
      failures++; $display("FAIL invuln_exit inv=%0b vis=%0b lives=%0d exp 0 1 2", invulnerable, playerVisible, lives);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (lifeLostPulse) pulses++;
    end
    checks++; if (pulses != 0 || lives !== 2'd2) begin failures++; $display("FAIL held_on_return pulses=%0d lives=%0d exp 0 2", pulses, lives); end
    playerHit = 1'b0; step();
  endtask

  task automatic test_bonus_and_simultaneous();
    // lives=2 PLAYING: hit and bonus together.
    playerHit = 1'b1; bonusLife = 1'b1; step(); playerHit = 1'b0; bonusLife = 1'b0;
    checks++; if (lives !== 2'd2 || invulnerable !== 1'b1 || lifeLostPulse !== 1'b1) begin
      failures++; $display("FAIL pair_at2 lives=%0d inv=%0b pulse=%0b exp 2 1 1", lives, invulnerable, lifeLostPulse);
    end
    run_frames(120);
    bonusLife = 1'b1; step(); bonusLife = 1'b0; step();
    checks++; if (lives !== 2'd3) begin failures++; $display("FAIL bonus_inc got=%0d exp=3", lives); end
    bonusLife = 1'b1; step(); bonusLife = 1'b0; step();
    checks++; if (lives !== 2'd3) begin failures++; $display("FAIL bonus_sat got=%0d exp=3", lives); end
    playerHit = 1'b1; step(); playerHit = 1'b0; step();
    run_frames(120);
    playerHit = 1'b1; step(); playerHit = 1'b0; step();
    checks++; if (lives !== 2'd1) begin failures++; $display("FAIL down_to1 got=%0d exp=1", lives); end
    // Bonus accepted during INVULN.
    bonusLife = 1'b1; step(); bonusLife = 1'b0; step();
    checks++; if (lives !== 2'd2 || invulnerable !== 1'b1) begin failures++; $display("FAIL bonus_invuln lives=%0d inv=%0b exp 2 1", lives, invulnerable); end
    run_frames(120);
    playerHit = 1'b1; step(); playerHit = 1'b0; step();
    run_frames(120);
    checks++; if (lives !== 2'd1 || invulnerable !== 1'b0) begin failures++; $display("FAIL setup_1 lives=%0d inv=%0b exp 1 0", lives, invulnerable); end
    playerHit = 1'b1; bonusLife = 1'b1; step(); playerHit = 1'b0; bonusLife = 1'b0;
    checks++; if (lives !== 2'd1 || gameOver !== 1'b0 || invulnerable !== 1'b1) begin
      failures++; $display("FAIL pair_at1 lives=%0d go=%0b inv=%0b exp 1 0 1", lives, gameOver, invulnerable);
    end
    run_frames(120);
  endtask

  task automatic test_game_over();
    playerHit = 1'b1; step(); playerHit = 1'b0;
    checks++; if (lives !== 2'd0 || gameOver !== 1'b1 || lifeLostPulse !== 1'b1) begin
      failures++; $display("FAIL fatal_hit lives=%0d go=%0b pulse=%0b exp 0 1 1", lives, gameOver, lifeLostPulse);
    end
    step();
    checks++; if (lifeLostPulse !== 1'b0 || playerVisible !== 1'b0 || invulnerable !== 1'b0) begin
      failures++; $display("FAIL go_after pulse=%0b vis=%0b inv=%0b exp 0 0 0", lifeLostPulse, playerVisible, invulnerable);
    end
    playerHit = 1'b1; step(); playerHit = 1'b0; bonusLife = 1'b1; step(); bonusLife = 1'b0; step();
    checks++; if (lives !== 2'd0 || gameOver !== 1'b1 || lifeLostPulse !== 1'b0) begin
      failures++; $display("FAIL go_ignore lives=%0d go=%0b pulse=%0b exp 0 1 0", lives, gameOver, lifeLostPulse);
    end
    // Restart with a coincident hit edge: the hit must be discarded.
    startGame = 1'b1; playerHit = 1'b1; step(); startGame = 1'b0;
    checks++; if (lives !== 2'd3 || gameOver !== 1'b0 || lifeLostPulse !== 1'b0 || invulnerable !== 1'b0) begin
      failures++; $display("FAIL restart lives=%0d go=%0b pulse=%0b inv=%0b exp 3 0 0 0", lives, gameOver, lifeLostPulse, invulnerable);
    end
    playerHit = 1'b0; step();
  endtask

  task automatic test_reset_mid_invuln();
    playerHit = 1'b1; step(); playerHit = 1'b0; step();
    run_frames(60);
    checks++; if (invulnerable !== 1'b1 || lives !== 2'd2) begin failures++; $display("FAIL pre_reset inv=%0b lives=%0d exp 1 2", invulnerable, lives); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (lives !== 2'd0 || invulnerable !== 1'b0 || playerVisible !== 1'b0 || gameOver !== 1'b0 || lifeLostPulse !== 1'b0) begin
      failures++; $display("FAIL async_reset lives=%0d inv=%0b vis=%0b go=%0b pulse=%0b exp all 0", lives, invulnerable, playerVisible, gameOver, lifeLostPulse);
    end
    step();
    resetN = 1'b1; step();
    playerHit = 1'b1; step(); step(); playerHit = 1'b0;
    checks++; if (lives !== 2'd0 || lifeLostPulse !== 1'b0 || invulnerable !== 1'b0 || playerVisible !== 1'b0) begin
      failures++; $display("FAIL post_reset_hit lives=%0d pulse=%0b inv=%0b vis=%0b exp all 0", lives, lifeLostPulse, invulnerable, playerVisible);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_start();
    test_hit_hold_and_blink();
    test_bonus_and_simultaneous();
    test_game_over();
    test_reset_mid_invuln();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
